// File: rtl/up_pkg.sv
// ---------------------------------------------------------------------------
// up_pkg -- shared definitions for the PC / fetch sequencer.
//
// Contents:
//   state_t        FSM state encoding (FETCH, EXEC, HALT)
//   ADDR_W_DFLT    default program counter / ROM address width
//   INSTR_W_DFLT   default ROM word width
//   OPC_W_DFLT     default opcode field width (upper bits of the word)
// ---------------------------------------------------------------------------
package up_pkg;

    localparam int ADDR_W_DFLT  = 12;
    localparam int INSTR_W_DFLT = 8;
    localparam int OPC_W_DFLT   = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage : up_pkg

// File: rtl/pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter -- loadable, enabled program counter.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, clears q to 0
//   inc       in   advance q by one (wraps modulo 2^ADDR_W)
//   load      in   load q from load_val (wins over inc)
//   load_val  in   ADDR_W value to load
//   q         out  ADDR_W current count
// ---------------------------------------------------------------------------
module pc_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] q
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    // NOTE: sequential state is always written with <= so every flop samples
    // its inputs before any of them update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= q + ONE;
        end
    end

endmodule : pc_counter

// File: rtl/pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// pc_fetch_seq -- two-phase instruction fetch sequencer.
//
// Fetches a word from an asynchronous-read ROM addressed by pc, latches it
// into the instruction register, and presents opcode/operand during EXEC.
// One instruction per two cycles without stalls.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   en           in   run enable, only sampled in FETCH
//   stall        in   hold the current state for this cycle
//   rom_addr     out  ROM address (= pc)
//   rom_data     in   ROM word at rom_addr
//   jump_valid   in   load jump_addr into pc at the end of EXEC
//   jump_addr    in   jump target
//   instr        out  opcode field of the instruction register
//   oprnd        out  operand field of the instruction register
//   instr_valid  out  high while in EXEC
//   phase        out  0 = FETCH, 1 = EXEC or HALT
//   pc           out  current program counter
//   pc_wrap      out  sticky wrap-error flag
//
// Build option PC_FETCH_WRAP_ERR_EN: when defined, fetching from the last
// address sets pc_wrap and parks the FSM in HALT until reset. When undefined,
// pc wraps silently, pc_wrap is tied low and HALT is unreachable.
// ---------------------------------------------------------------------------
module pc_fetch_seq
    import up_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DFLT,
    parameter int INSTR_W = INSTR_W_DFLT,
    parameter int OPC_W   = OPC_W_DFLT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     stall,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [INSTR_W-1:0]       rom_data,
    input  logic                     jump_valid,
    input  logic [ADDR_W-1:0]        jump_addr,
    output logic [OPC_W-1:0]         instr,
    output logic [INSTR_W-OPC_W-1:0] oprnd,
    output logic                     instr_valid,
    output logic                     phase,
    output logic [ADDR_W-1:0]        pc,
    output logic                     pc_wrap
);

    state_t               state;
    state_t               state_nxt;
    logic [INSTR_W-1:0]   ir;
    logic                 fetch_go;
    logic                 jump_take;
    logic                 wrap_halt;

    // A fetch happens only from FETCH; en is deliberately not looked at in
    // EXEC so an instruction in flight always completes.
    assign fetch_go  = (state == FETCH) && en && !stall;
    assign jump_take = (state == EXEC) && !stall && jump_valid;

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .inc      (fetch_go),
        .load     (jump_take),
        .load_val (jump_addr),
        .q        (pc)
    );

    // Instruction register: loaded on every fetch, including the wrapping one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (fetch_go) begin
            ir <= rom_data;
        end
    end

`ifdef PC_FETCH_WRAP_ERR_EN
    // Fetching from the all-ones address is the wrap error.
    assign wrap_halt = fetch_go && (&pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_wrap <= 1'b0;
        end else if (wrap_halt) begin
            pc_wrap <= 1'b1;
        end
    end
`else
    assign wrap_halt = 1'b0;
    assign pc_wrap   = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic
    // NOTE: the default assignment ahead of the case keeps this block purely
    // combinational; a path that left state_nxt unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (fetch_go) begin
                    state_nxt = wrap_halt ? HALT : EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    state_nxt = FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    // FSM: outputs
    always_comb begin
        instr_valid = (state == EXEC);
        phase       = (state != FETCH);
        rom_addr    = pc;
        instr       = ir[INSTR_W-1:INSTR_W-OPC_W];
        oprnd       = ir[INSTR_W-OPC_W-1:0];
    end

endmodule : pc_fetch_seq

// File: tb/tb_pc_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_seq -- scoreboard bench for pc_fetch_seq.
//
// The stimulus process drives inputs on the falling edge, advances a
// behavioural reference model by one cycle and pushes the outputs the DUT
// must show after the next rising edge. A separate monitor pops one entry
// per rising edge and compares it with the DUT outputs.
// Honours PC_FETCH_WRAP_ERR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pc_fetch_seq;

    localparam int AW = 12;
    localparam int IW = 8;
    localparam int OW = 4;
    localparam int DEPTH = 1 << AW;

    // Reference model state
    localparam int M_FETCH = 0;
    localparam int M_EXEC  = 1;
    localparam int M_HALT  = 2;

    typedef struct {
        int unsigned pc;
        int unsigned instr;
        int unsigned oprnd;
        int unsigned valid;
        int unsigned phase;
        int unsigned wrap;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            en;
    logic            stall;
    logic [AW-1:0]   rom_addr;
    logic [IW-1:0]   rom_data;
    logic            jump_valid;
    logic [AW-1:0]   jump_addr;
    logic [OW-1:0]   instr;
    logic [IW-OW-1:0] oprnd;
    logic            instr_valid;
    logic            phase;
    logic [AW-1:0]   pc;
    logic            pc_wrap;

    logic [IW-1:0]   rom [DEPTH];

    int unsigned m_pc;
    int unsigned m_ir;
    int          m_state;
    int unsigned m_wrap;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    pc_fetch_seq dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .stall       (stall),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr),
        .instr       (instr),
        .oprnd       (oprnd),
        .instr_valid (instr_valid),
        .phase       (phase),
        .pc          (pc),
        .pc_wrap     (pc_wrap)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue the
    // outputs expected after the coming rising edge.
    task automatic step(input logic r, input logic e, input logic s,
                        input logic j, input logic [AW-1:0] a);
        exp_t x;
        @(negedge clk);
        reset      = r;
        en         = e;
        stall      = s;
        jump_valid = j;
        jump_addr  = a;

        if (r) begin
            m_pc = 0; m_ir = 0; m_state = M_FETCH; m_wrap = 0;
        end else if (m_state == M_FETCH) begin
            if (e && !s) begin
                m_ir = rom[m_pc];
`ifdef PC_FETCH_WRAP_ERR_EN
                if (m_pc == DEPTH - 1) begin
                    m_wrap  = 1;
                    m_state = M_HALT;
                end else begin
                    m_state = M_EXEC;
                end
`else
                m_state = M_EXEC;
`endif
                m_pc = (m_pc + 1) % DEPTH;
            end
        end else if (m_state == M_EXEC) begin
            if (!s) begin
                if (j) m_pc = a;
                m_state = M_FETCH;
            end
        end

        x.pc    = m_pc;
        x.instr = m_ir / 16;
        x.oprnd = m_ir % 16;
        x.valid = (m_state == M_EXEC) ? 1 : 0;
        x.phase = (m_state == M_FETCH) ? 0 : 1;
        x.wrap  = m_wrap;
        sb_q.push_back(x);
    endtask

    // Monitor: one expected entry per rising edge once stimulus has begun.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                check("pc",          pc,          x.pc);
                check("rom_addr",    rom_addr,    x.pc);
                check("instr",       instr,       x.instr);
                check("oprnd",       oprnd,       x.oprnd);
                check("instr_valid", instr_valid, x.valid);
                check("phase",       phase,       x.phase);
                check("pc_wrap",     pc_wrap,     x.wrap);
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; stall = 1'b0; jump_valid = 1'b0; jump_addr = '0;
        for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
        rom[0] = 8'hA5;
        rom[1] = 8'h3C;
        m_pc = 0; m_ir = 0; m_state = M_FETCH; m_wrap = 0;

        // Reset state
        step(1, 0, 0, 0, 12'h000);
        step(1, 1, 0, 1, 12'h123);

        // Two plain fetches: A5 then 3C
        step(0, 1, 0, 0, 12'h000);
        step(0, 1, 0, 0, 12'h000);
        step(0, 1, 0, 0, 12'h000);

        // Jump in EXEC to 0x100, then a jump pulse in FETCH that must be ignored
        step(0, 1, 0, 1, 12'h100);
        step(0, 1, 0, 1, 12'h055);

        // Stall three cycles in EXEC with a jump presented, then release
        step(0, 1, 1, 1, 12'h200);
        step(0, 1, 1, 1, 12'h200);
        step(0, 1, 1, 1, 12'h200);
        step(0, 1, 0, 0, 12'h000);

        // en low in FETCH for five cycles
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 12'h000);

        // Fetch, then drop en in EXEC: EXEC completes, block waits in FETCH
        step(0, 1, 0, 0, 12'h000);
        step(0, 0, 0, 0, 12'h000);
        step(0, 0, 0, 0, 12'h000);
        step(0, 0, 1, 0, 12'h000);

        // Force pc to the last address, then fetch across the wrap
        step(0, 1, 0, 0, 12'h000);
        step(0, 1, 0, 1, 12'hFFF);
        step(0, 1, 0, 0, 12'h000);
        step(0, 1, 0, 1, 12'h0AA);
        step(0, 1, 0, 0, 12'h000);
        step(0, 1, 0, 1, 12'h0BB);

        // Reset in EXEC with a jump pending
        step(1, 0, 0, 0, 12'h000);
        step(0, 1, 0, 0, 12'h000);
        step(1, 1, 0, 1, 12'h321);
        step(0, 0, 0, 0, 12'h000);

        // Randomized traffic with occasional resets and jumps to the last address
        for (int i = 0; i < 3000; i++) begin
            logic          r, e, s, j;
            logic [AW-1:0] a;
            r = ($urandom_range(0, 79) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0);
            j = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 7) == 0) ? 12'hFFF : AW'($urandom);
            step(r, e, s, j, a);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_fetch_seq
